// File: rtl/adder_tree_arbiter_pkg.sv
// Shared types and width helpers for the adder_tree front-end arbiter.
// Pure declarations: no latency, no flow control.
package adder_tree_pkg;

  // Tag ids are carried at a fixed width so tag_t stays a plain typedef (NUM_REQ <= 256).
  localparam int unsigned TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int unsigned calc_rw(input int unsigned dw, input int unsigned n);
    return dw + $clog2(n);
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned lat);
    return $clog2(lat + 2);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_tree_arbiter_rr.sv
// Round-robin pick: first eligible requester at or after ptr, wrapping.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter
  import adder_tree_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = calc_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    grant     = '0;
    grant_idx = '0;
    grant_vld = |eligible;
    j         = 0;
    jj        = '0;
    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (eligible[jj]) grant_idx = jj;
    end
    grant[grant_idx] = grant_vld;
  end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one pipelined adder_tree among NUM_REQ requesters; request-to-result TREE_LATENCY+2.
// One issue per cycle via combinational req_ready; results are strobes with no backpressure.
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int NUM_INPUTS   = 10,
  parameter  int DATA_WIDTH   = 16,
  parameter  int TREE_LATENCY = 4,
  localparam int RW           = calc_rw(DATA_WIDTH, NUM_INPUTS),
  localparam int CNT_W        = calc_cnt_w(TREE_LATENCY),
  localparam int IDX_W        = calc_idx_w(NUM_REQ),
  localparam int VEC_W        = NUM_INPUTS * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VEC_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     tree_valid_in,
  output logic [VEC_W-1:0]         tree_data_in,
  input  logic                     tree_valid_out,
  input  logic [RW-1:0]            tree_data_out,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [RW-1:0]            res_data,
  output logic [CNT_W-1:0]         in_flight,
  output logic                     tag_error
);

  logic [VEC_W-1:0] req_vec [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_vec[g] = req_data[g*VEC_W +: VEC_W];
  end

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               hs;

  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    tree_valid_in_q, tree_valid_in_d;
  logic [VEC_W-1:0]        tree_data_in_q, tree_data_in_d;
  logic [IDX_W-1:0]        issue_id_q, issue_id_d;
  tag_t [TREE_LATENCY-1:0] tag_pipe_q, tag_pipe_d;
  logic [NUM_REQ-1:0]      res_valid_q, res_valid_d;
  logic [RW-1:0]           res_data_q, res_data_d;
  logic [CNT_W-1:0]        in_flight_q, in_flight_d;
  logic                    tag_error_q, tag_error_d;
  tag_t                    tag_out;

  assign eligible = req_valid & req_enable;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Nothing is accepted while reset is held, so req_ready reads zero with the other outputs.
  assign req_ready = rst ? '0 : grant;
  assign hs        = grant_vld & ~rst;
  assign tag_out   = tag_pipe_q[TREE_LATENCY-1];

  always_comb begin
    ptr_d           = ptr_q;
    tree_valid_in_d = hs;
    tree_data_in_d  = tree_data_in_q;
    issue_id_d      = issue_id_q;
    if (hs) begin
      ptr_d          = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      tree_data_in_d = req_vec[grant_idx];
      issue_id_d     = grant_idx;
    end
  end

  always_comb begin
    tag_pipe_d    = tag_pipe_q;
    tag_pipe_d[0] = '{valid: tree_valid_in_q, id: TAG_ID_W'(issue_id_q)};
    for (int i = 1; i < TREE_LATENCY; i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  // A result is routed only when the tree strobe and the expected tag agree.
  always_comb begin
    res_valid_d = '0;
    res_data_d  = res_data_q;
    tag_error_d = tag_error_q | (tag_out.valid != tree_valid_out);
    if (tag_out.valid && tree_valid_out) begin
      res_valid_d[tag_out.id[IDX_W-1:0]] = 1'b1;
      res_data_d                         = tree_data_out;
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    case ({tree_valid_in_q, tag_out.valid})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      tree_valid_in_q <= 1'b0;
      tree_data_in_q  <= '0;
      issue_id_q      <= '0;
      tag_pipe_q      <= '0;
      res_valid_q     <= '0;
      res_data_q      <= '0;
      in_flight_q     <= '0;
      tag_error_q     <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      tree_valid_in_q <= tree_valid_in_d;
      tree_data_in_q  <= tree_data_in_d;
      issue_id_q      <= issue_id_d;
      tag_pipe_q      <= tag_pipe_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      in_flight_q     <= in_flight_d;
      tag_error_q     <= tag_error_d;
    end
  end

  assign tree_valid_in = tree_valid_in_q;
  assign tree_data_in  = tree_data_in_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign in_flight     = in_flight_q;
  assign tag_error     = tag_error_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter with a behavioural adder tree and per-requester scoreboards.
module tb_adder_tree_arbiter;

  localparam int NREQ = 4;
  localparam int NI   = 10;
  localparam int DW   = 16;
  localparam int LAT  = 4;
  localparam int RW   = DW + $clog2(NI);
  localparam int CW   = $clog2(LAT + 2);
  localparam int VW   = NI * DW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_enable = '0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*VW-1:0]    req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  tree_valid_in;
  logic [VW-1:0]         tree_data_in;
  logic                  tree_valid_out;
  logic [RW-1:0]         tree_data_out;
  logic [NREQ-1:0]       res_valid;
  logic [RW-1:0]         res_data;
  logic [CW-1:0]         in_flight;
  logic                  tag_error;
  logic                  force_vo = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_q [NREQ][$];
  int exp_t [NREQ][$];
  int got_q [NREQ][$];
  int got_t [NREQ][$];

  adder_tree_arbiter #(
    .NUM_REQ      (NREQ),
    .NUM_INPUTS   (NI),
    .DATA_WIDTH   (DW),
    .TREE_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_enable     (req_enable),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .tree_valid_in  (tree_valid_in),
    .tree_data_in   (tree_data_in),
    .tree_valid_out (tree_valid_out),
    .tree_data_out  (tree_data_out),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .in_flight      (in_flight),
    .tag_error      (tag_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int vec_sum(input logic [VW-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < NI; i++) s += int'($signed(v[i*DW +: DW]));
    return s;
  endfunction

  // Behavioural adder tree sharing rst with the arbiter.
  logic          mv [LAT];
  logic [RW-1:0] ms [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin mv[i] <= 1'b0; ms[i] <= '0; end
    end else begin
      mv[0] <= tree_valid_in;
      ms[0] <= RW'(vec_sum(tree_data_in));
      for (int i = 1; i < LAT; i++) begin mv[i] <= mv[i-1]; ms[i] <= ms[i-1]; end
    end
  end
  assign tree_valid_out = mv[LAT-1] | force_vo;
  assign tree_data_out  = ms[LAT-1];

  // Record handshakes (expected sum and arrival cycle) and results; tests compare.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q[i].push_back(vec_sum(req_data[i*VW +: VW]));
          exp_t[i].push_back(cyc + LAT + 2);
        end
        if (res_valid[i]) begin
          got_q[i].push_back(int'($signed(res_data)));
          got_t[i].push_back(cyc);
        end
      end
    end
  end

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      exp_q[i].delete(); exp_t[i].delete(); got_q[i].delete(); got_t[i].delete();
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ * NI; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_enable = '0; req_data = '0; force_vo = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_queues();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_enable = '1;
    rand_data();
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (tree_valid_in !== 1'b0) begin errors++; $display("FAIL reset_tree_valid_in got %b want 0", tree_valid_in); end
    checks++; if (tree_data_in !== '0) begin errors++; $display("FAIL reset_tree_data_in got %h want 0", tree_data_in); end
    checks++; if (res_valid !== '0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
    checks++; if (in_flight !== '0) begin errors++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL reset_tag_error got %b want 0", tag_error); end
    do_reset();
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    req_enable = '1; req_valid = 4'b0100;
    for (int k = 0; k < NI; k++) req_data[2*VW + k*DW +: DW] = 16'd3;
    @(negedge clk);
    c0 = cyc;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got_q[2].size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q[2].size()); end
    else begin
      checks++; if (got_q[2][0] !== 30) begin errors++; $display("FAIL single_sum got %0d want 30", got_q[2][0]); end
      checks++; if (got_t[2][0] - c0 !== LAT + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", got_t[2][0] - c0, LAT + 2); end
    end
    checks++;
    if (got_q[0].size() + got_q[1].size() + got_q[3].size() !== 0) begin
      errors++; $display("FAIL single_stray got %0d results want 0", got_q[0].size() + got_q[1].size() + got_q[3].size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_enable = '1; req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      @(negedge clk);
      checks++;
      if (req_ready !== (4'b0001 << (c % 4))) begin
        errors++; $display("FAIL b2b_grant cycle %0d got %b want %b", c, req_ready, 4'b0001 << (c % 4));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (got_q[i].size() !== 3 || exp_q[i].size() !== 3) begin
        errors++; $display("FAIL b2b_count req%0d got %0d exp %0d want 3", i, got_q[i].size(), exp_q[i].size());
      end
      while (got_q[i].size() > 0 && exp_q[i].size() > 0) begin
        int g, e, gt, et;
        g = got_q[i].pop_front(); e = exp_q[i].pop_front();
        gt = got_t[i].pop_front(); et = exp_t[i].pop_front();
        checks++;
        if (g !== e || gt !== et) begin
          errors++; $display("FAIL b2b_result req%0d got %0d@%0d want %0d@%0d", i, g, gt, e, et);
        end
      end
    end
  endtask

  task automatic test_enable_mask();
    int seq [3] = '{0, 2, 3};
    do_reset();
    req_enable = 4'b1101; req_valid = '1;
    for (int c = 0; c < 9; c++) begin
      rand_data();
      @(negedge clk);
      checks++;
      if (req_ready !== (4'b0001 << seq[c % 3])) begin
        errors++; $display("FAIL mask_grant cycle %0d got %b want %b", c, req_ready, 4'b0001 << seq[c % 3]);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    checks++;
    if (got_q[1].size() !== 0 || got_q[0].size() !== 3) begin
      errors++; $display("FAIL mask_results req1 got %0d want 0, req0 got %0d want 3", got_q[1].size(), got_q[0].size());
    end
  endtask

  task automatic test_min_values();
    do_reset();
    req_enable = '1; req_valid = 4'b0001;
    for (int k = 0; k < NI; k++) req_data[k*DW +: DW] = 16'h8000;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    checks++;
    if (got_q[0].size() !== 1) begin errors++; $display("FAIL min_count got %0d want 1", got_q[0].size()); end
    else begin
      checks++; if (got_q[0][0] !== -327680) begin errors++; $display("FAIL min_sum got %0d want -327680", got_q[0][0]); end
    end
  endtask

  task automatic test_tag_error();
    do_reset();
    force_vo = 1'b1;
    @(posedge clk); #1;
    force_vo = 1'b0;
    @(negedge clk);
    checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL tagerr_set got %b want 1", tag_error); end
    checks++; if (res_valid !== '0) begin errors++; $display("FAIL tagerr_res_valid got %b want 0", res_valid); end
    repeat (5) @(negedge clk);
    checks++; if (tag_error !== 1'b1) begin errors++; $display("FAIL tagerr_sticky got %b want 1", tag_error); end
    checks++;
    if (got_q[0].size() + got_q[1].size() + got_q[2].size() + got_q[3].size() !== 0) begin
      errors++; $display("FAIL tagerr_results got results want none");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_enable = '1; req_valid = 4'b0100;
    repeat (3) @(posedge clk);
    #1; req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_flight !== CW'(3)) begin errors++; $display("FAIL mid_in_flight got %0d want 3", in_flight); end
    #1; rst = 1'b1;
    #1;
    checks++; if (in_flight !== '0) begin errors++; $display("FAIL mid_rst_in_flight got %0d want 0", in_flight); end
    checks++; if (tree_valid_in !== 1'b0) begin errors++; $display("FAIL mid_rst_tree_valid got %b want 0", tree_valid_in); end
    checks++;
    if ({req_ready, res_valid, tag_error} !== '0 || tree_data_in !== '0 || res_data !== '0) begin
      errors++; $display("FAIL mid_rst_outputs got ready %b res %b err %b data %h sum %h want 0", req_ready, res_valid, tag_error, tree_data_in, res_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_queues();
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL mid_tag_error got %b want 0", tag_error); end
  endtask

  task automatic test_random();
    int ptr;
    logic [NREQ-1:0] elig, want;
    do_reset();
    ptr = 0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]  = ($urandom_range(0, 99) < 70);
        req_enable[i] = ($urandom_range(0, 99) < 80);
      end
      rand_data();
      @(negedge clk);
      elig = req_valid & req_enable;
      want = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (elig[(ptr + k) % NREQ]) begin
          want[(ptr + k) % NREQ] = 1'b1;
          ptr = (ptr + k + 1) % NREQ;
          break;
        end
      end
      checks++;
      if (req_ready !== want) begin errors++; $display("FAIL rand_grant cycle %0d got %b want %b", c, req_ready, want); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (got_q[i].size() !== exp_q[i].size()) begin
        errors++; $display("FAIL rand_count req%0d got %0d want %0d", i, got_q[i].size(), exp_q[i].size());
      end
      while (got_q[i].size() > 0 && exp_q[i].size() > 0) begin
        int g, e, gt, et;
        g = got_q[i].pop_front(); e = exp_q[i].pop_front();
        gt = got_t[i].pop_front(); et = exp_t[i].pop_front();
        checks++;
        if (g !== e || gt !== et) begin
          errors++; $display("FAIL rand_result req%0d got %0d@%0d want %0d@%0d", i, g, gt, e, et);
        end
      end
    end
    checks++; if (tag_error !== 1'b0) begin errors++; $display("FAIL rand_tag_error got %b want 0", tag_error); end
    checks++; if (in_flight !== '0) begin errors++; $display("FAIL rand_in_flight got %0d want 0", in_flight); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_mask();
    test_min_values();
    test_tag_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
